mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum bus-wait cycles before abort.
REQ-002 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-004 SHALL have EX-side ports:
- ex_valid in 1
- ex_ready out 1
- ex_wd in 5
- ex_wreg in 1
- ex_wdata in 32: ALU result or effective address.
- ex_memop in 4: memop code.
- ex_sdata in 32: store data.
REQ-005 SHALL have data-bus ports:
- dbus_req out 1
- dbus_we out 1
- dbus_addr out 32: word-aligned.
- dbus_be out 4
- dbus_wdata out 32
- dbus_ack in 1
- dbus_rdata in 32
- dbus_err in 1
REQ-006 SHALL have forwarding ports to the register file:
- mem_wd out 5
- mem_wreg out 1
- mem_wdata out 32
- load_pending out 1
REQ-007 SHALL have write-back ports: wb_we out 1, wb_waddr out 5, wb_wdata out 32.
REQ-008 SHALL have exception ports: exc_valid out 1, exc_cause out 2 (1 misalign, 2 bus error, 3 timeout), exc_addr out 32.

Function
REQ-009 SHALL hold one M-stage slot and one W-stage register, with FSM states IDLE (slot empty), HOLD (complete result), ACCESS (bus outstanding).
REQ-010 SHALL drive ex_ready=1 in IDLE/HOLD and 0 in ACCESS; accept on ex_valid&&ex_ready rising edge.
REQ-011 SHALL support memops NONE, LB, LH, LW, LBU, LHU, SB, SH, SW; NONE goes to HOLD, any other to ACCESS.
REQ-012 SHALL assert dbus_req for every ACCESS cycle, with bus outputs stable until the dbus_ack cycle.
REQ-013 SHALL use zero-wait ack: ack in the first ACCESS cycle completes the access.
REQ-014 SHALL register dbus_rdata on ack, byte/half selected by addr[1:0], sign- or zero-extended per memop, then go to HOLD.
REQ-015 SHALL generate store byte-enables: SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111; store data replicated across lanes.
REQ-016 SHALL force mem_wreg=0 for stores.
REQ-017 SHALL drive mem_wd/mem_wreg/mem_wdata from the slot only in HOLD; otherwise mem_wreg=0. SHALL drive load_pending=1 in ACCESS when the slot is a load with wreg=1.
REQ-018 SHALL load W from a HOLD slot every edge; W we=0 when the slot is not in HOLD.
REQ-019 SHALL force wb_we=0 when wb_waddr=0.
REQ-020 SHALL have latency: non-memory op accepted at edge N gives mem_* in cycle N+1 and wb_* in N+2; load with ack at first request gives mem_* at N+2 and wb_* at N+3.
REQ-021 SHALL accept a new op on the same edge a HOLD slot retires to W (back-to-back, no bubble).
REQ-022 SHALL count ACCESS cycles with an 8-bit counter; reaching TIMEOUT_CYCLES without ack SHALL abort: drop req, exception cause 3, no write-back, go to IDLE.
REQ-023 SHALL treat ack with dbus_err=1 as an abort with cause 2.
REQ-024 SHALL pulse exc_valid for one cycle, with exc_addr = faulting address.

Reset
REQ-025 SHALL, on rst high, immediately set the FSM to IDLE, clear the counter, and drive all outputs to 0 except ex_ready=1.
REQ-026 SHALL drop dbus_req combinationally during reset, including mid-ACCESS; the pending access is discarded.

Configuration
REQ-027 SHALL support macro MEM_MISALIGN_CHECK_EN:
- Defined: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, raise cause 1 in the accept+1 cycle, issue no bus request, write nothing, and go to IDLE.
- Undefined: offending low address bits are ignored (treated as 0) and no cause-1 exception is raised.

Structure
REQ-028 SHALL take memop codes, exception cause codes and FSM state encodings from shared package riscv_pkg.
REQ-029 SHALL place lane extraction, extension and byte-enable generation in combinational sub-module mem_align.

Verification
REQ-030 SHALL cover: ADD wd=5 wdata=0x1234 -> mem_wd=5, mem_wdata=0x1234 at N+1; wb_we=1, wb_waddr=5 at N+2.
REQ-031 SHALL cover: LB addr 0x103, ack after 3 wait cycles, rdata 0x80FF_FFFF -> load_pending high 4 cycles, ex_ready=0, wb_wdata=0xFFFF_FF80.
REQ-032 SHALL cover: SH addr 0x202, sdata 0xABCD -> dbus_be=1100, dbus_wdata=0xABCD_ABCD, dbus_addr=0x200, wb_we=0.
REQ-033 SHALL cover: LW with ack withheld for 255 cycles -> exc_cause=3 pulse, req dropped, no write-back.
REQ-034 SHALL cover: with MEM_MISALIGN_CHECK_EN, LW addr 0x301 -> exc_cause=1 and no dbus_req; without it, dbus_addr=0x300.
REQ-035 SHALL cover: rst asserted mid-ACCESS -> dbus_req=0 the same cycle, FSM IDLE, a post-reset op proceeds normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared memop, exception cause and M-stage FSM encodings
package riscv_pkg;

    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LH   = 4'd2,
        MEMOP_LW   = 4'd3,
        MEMOP_LBU  = 4'd4,
        MEMOP_LHU  = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_BUS_ERR  = 2'd2,
        EXC_TIMEOUT  = 2'd3
    } exc_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_ACCESS = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
               (op == MEMOP_LBU) || (op == MEMOP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        return (((op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH)) && lo[0]) ||
               (((op == MEMOP_LW) || (op == MEMOP_SW)) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - load lane extraction/extension and store byte-enable/lane replication
module mem_align
    import riscv_pkg::*;
(
    input  logic [3:0]  memop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    output logic [31:0] load_data,
    output logic [3:0]  be,
    output logic [31:0] store_data
);

    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        // Low bits that would misalign a half/word are ignored, not trapped, here.
        off = addr_lo;
        if ((memop == MEMOP_LH) || (memop == MEMOP_LHU) || (memop == MEMOP_SH))
            off = {addr_lo[1], 1'b0};
        else if ((memop == MEMOP_LW) || (memop == MEMOP_SW))
            off = 2'b00;

        shifted    = rdata >> {off, 3'b000};
        load_data  = 32'd0;
        be         = 4'b0000;
        store_data = sdata;

        case (memop)
            MEMOP_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            MEMOP_LBU: load_data = {24'd0, shifted[7:0]};
            MEMOP_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            MEMOP_LHU: load_data = {16'd0, shifted[15:0]};
            MEMOP_LW:  load_data = rdata;
            MEMOP_SB: begin
                be         = 4'b0001 << off;
                store_data = {4{sdata[7:0]}};
            end
            MEMOP_SH: begin
                be         = 4'b0011 << off;
                store_data = {2{sdata[15:0]}};
            end
            MEMOP_SW:  be = 4'b1111;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - M/W pipeline stage with data-bus FSM; MEM_MISALIGN_CHECK_EN enables alignment traps
module mem_access
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_sdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_err,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        load_pending,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_e  state_q, state_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  memop_q, memop_d;
    logic [31:0] sdata_q, sdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        exc_valid_q, exc_valid_d;
    logic [1:0]  exc_cause_q, exc_cause_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_waddr_q, wb_waddr_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;

    logic [31:0] load_data, store_data;
    logic [3:0]  be;
    logic        in_access, in_hold;

    mem_align u_align (
        .memop      (memop_q),
        .addr_lo    (data_q[1:0]),
        .rdata      (dbus_rdata),
        .sdata      (sdata_q),
        .load_data  (load_data),
        .be         (be),
        .store_data (store_data)
    );

    assign in_access    = (state_q == ST_ACCESS);
    assign in_hold      = (state_q == ST_HOLD);
    assign ex_ready     = !in_access;
    assign dbus_req     = in_access && !rst;
    assign dbus_we      = in_access && is_store(memop_q);
    assign dbus_addr    = in_access ? {data_q[31:2], 2'b00} : 32'd0;
    assign dbus_be      = in_access ? be : 4'b0000;
    assign dbus_wdata   = in_access ? store_data : 32'd0;
    assign mem_wd       = in_hold ? wd_q : 5'd0;
    assign mem_wreg     = in_hold && wreg_q;
    assign mem_wdata    = in_hold ? data_q : 32'd0;
    assign load_pending = in_access && is_load(memop_q) && wreg_q;
    assign wb_we        = wb_we_q;
    assign wb_waddr     = wb_waddr_q;
    assign wb_wdata     = wb_wdata_q;
    assign exc_valid    = exc_valid_q;
    assign exc_cause    = exc_cause_q;
    assign exc_addr     = exc_addr_q;

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        data_d      = data_q;
        memop_d     = memop_q;
        sdata_d     = sdata_q;
        cnt_d       = cnt_q;
        exc_valid_d = 1'b0;
        exc_cause_d = EXC_NONE;
        exc_addr_d  = 32'd0;
        // W samples the HOLD slot every edge; mem_* are already zero outside HOLD.
        wb_we_d     = mem_wreg && (mem_wd != 5'd0);
        wb_waddr_d  = mem_wd;
        wb_wdata_d  = mem_wdata;

        if (in_access) begin
            cnt_d = cnt_q + 8'd1;
            if (dbus_ack) begin
                if (dbus_err) begin
                    state_d     = ST_IDLE;
                    exc_valid_d = 1'b1;
                    exc_cause_d = EXC_BUS_ERR;
                    exc_addr_d  = data_q;
                end else begin
                    state_d = ST_HOLD;
                    if (is_load(memop_q))
                        data_d = load_data;
                end
            end else if (cnt_q == TO_LAST) begin
                state_d     = ST_IDLE;
                exc_valid_d = 1'b1;
                exc_cause_d = EXC_TIMEOUT;
                exc_addr_d  = data_q;
            end
        end else begin
            state_d = ST_IDLE;
            if (ex_valid) begin
                wd_d    = ex_wd;
                wreg_d  = ex_wreg && !is_store(ex_memop);
                data_d  = ex_wdata;
                memop_d = ex_memop;
                sdata_d = ex_sdata;
                cnt_d   = 8'd0;
                state_d = (ex_memop == MEMOP_NONE) ? ST_HOLD : ST_ACCESS;
`ifdef MEM_MISALIGN_CHECK_EN
                if (is_misaligned(ex_memop, ex_wdata[1:0])) begin
                    state_d     = ST_IDLE;
                    exc_valid_d = 1'b1;
                    exc_cause_d = EXC_MISALIGN;
                    exc_addr_d  = ex_wdata;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wd_q        <= 5'd0;
            wreg_q      <= 1'b0;
            data_q      <= 32'd0;
            memop_q     <= 4'd0;
            sdata_q     <= 32'd0;
            cnt_q       <= 8'd0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 2'd0;
            exc_addr_q  <= 32'd0;
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= 5'd0;
            wb_wdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            data_q      <= data_d;
            memop_q     <= memop_d;
            sdata_q     <= sdata_d;
            cnt_q       <= cnt_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
            wb_we_q     <= wb_we_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed bench with write-back scoreboard for mem_access
module tb_mem_access;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic [3:0]  ex_memop = '0;
    logic [31:0] ex_sdata = '0;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        dbus_err = 1'b0;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        load_pending;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] sb[$];

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_wdata(ex_wdata), .ex_memop(ex_memop), .ex_sdata(ex_sdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .load_pending(load_pending),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] sdata);
        ex_valid = 1'b1; ex_memop = op; ex_wd = wd; ex_wreg = wreg;
        ex_wdata = wdata; ex_sdata = sdata;
        tick();
        ex_valid = 1'b0;
    endtask

    // Load with 'waits' un-acked request cycles before the ack cycle.
    task automatic do_load(input logic [3:0] op, input logic [4:0] wd, input logic [31:0] addr,
                           input int waits, input logic [31:0] rdata, input logic [31:0] exp);
        int lp = 0;
        sb.push_back({wd, exp});
        issue(op, wd, 1'b1, addr, 32'd0);
        check("load_addr", {5'd0, dbus_addr}, {5'd0, addr & 32'hFFFF_FFFC});
        for (int i = 0; i <= waits; i++) begin
            if (load_pending && !ex_ready && dbus_req) lp++;
            if (i == waits) begin dbus_ack = 1'b1; dbus_rdata = rdata; end
            tick();
        end
        dbus_ack = 1'b0;
        check("load_pending_cycles", 37'(lp), 37'(waits + 1));
        check("load_mem_wdata", {mem_wreg, mem_wd, mem_wdata}, {1'b1, wd, exp});
    endtask

    // Every write-back must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_we) begin
            if (sb.size() == 0) check("unexpected_wb", {wb_waddr, wb_wdata}, 37'd0);
            else check("wb", {wb_waddr, wb_wdata}, sb.pop_front());
        end
    end

    initial begin
        int req_cycles;
        #1;
        check("rst_ex_ready", 37'(ex_ready), 37'd1);
        check("rst_outs", {dbus_req, mem_wreg, load_pending, wb_we, exc_valid, dbus_addr},
              37'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        sb.push_back({5'd5, 32'h1234});
        issue(MEMOP_NONE, 5'd5, 1'b1, 32'h1234, 32'd0);
        check("add_mem", {mem_wreg, mem_wd, mem_wdata}, {1'b1, 5'd5, 32'h1234});
        tick();
        check("add_wb_we", 37'(wb_we), 37'd1);

        sb.push_back({5'd6, 32'h11});
        sb.push_back({5'd7, 32'h22});
        issue(MEMOP_NONE, 5'd6, 1'b1, 32'h11, 32'd0);
        check("b2b_ready", 37'(ex_ready), 37'd1);
        issue(MEMOP_NONE, 5'd7, 1'b1, 32'h22, 32'd0);
        check("b2b_mem", {mem_wreg, mem_wd, mem_wdata}, {1'b1, 5'd7, 32'h22});
        tick();

        issue(MEMOP_NONE, 5'd0, 1'b1, 32'h99, 32'd0);
        tick(); tick();

        do_load(MEMOP_LB,  5'd9,  32'h103, 3, 32'h80FF_FFFF, 32'hFFFF_FF80);
        tick();
        do_load(MEMOP_LHU, 5'd11, 32'h402, 0, 32'h8001_7F00, 32'h0000_8001);
        do_load(MEMOP_LH,  5'd12, 32'h400, 1, 32'h8001_F00D, 32'hFFFF_F00D);
        do_load(MEMOP_LBU, 5'd13, 32'h102, 0, 32'h0081_0000, 32'h0000_0081);
        do_load(MEMOP_LW,  5'd14, 32'h404, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick();

        issue(MEMOP_SH, 5'd3, 1'b1, 32'h202, 32'h0000_ABCD);
        check("sh_bus", {dbus_req, dbus_we, dbus_be, dbus_addr}, {1'b1, 1'b1, 4'b1100, 32'h200});
        check("sh_wdata", {5'd0, dbus_wdata}, {5'd0, 32'hABCD_ABCD});
        dbus_ack = 1'b1; tick(); dbus_ack = 1'b0;
        check("sh_mem_wreg", 37'(mem_wreg), 37'd0);
        issue(MEMOP_SB, 5'd3, 1'b1, 32'h501, 32'h0000_0077);
        check("sb_bus", {dbus_be, dbus_wdata}, {1'b0, 4'b0010, 32'h7777_7777});
        dbus_ack = 1'b1; tick(); dbus_ack = 1'b0;
        tick();

        issue(MEMOP_LW, 5'd4, 1'b1, 32'h600, 32'd0);
        req_cycles = 0;
        for (int i = 0; i < 300; i++) begin
            if (exc_valid) break;
            if (dbus_req) req_cycles++;
            tick();
        end
        check("to_req_cycles", 37'(req_cycles), 37'd255);
        check("to_exc", {exc_valid, exc_cause, dbus_req, exc_addr}, {1'b1, 2'd3, 1'b0, 32'h600});
        tick();
        check("to_pulse", {exc_valid, ex_ready}, {1'b0, 1'b1});

        issue(MEMOP_LW, 5'd4, 1'b1, 32'h700, 32'd0);
        dbus_ack = 1'b1; dbus_err = 1'b1; tick(); dbus_ack = 1'b0; dbus_err = 1'b0;
        check("err_exc", {exc_valid, exc_cause, exc_addr}, {1'b1, 2'd2, 32'h700});
        tick();

`ifdef MEM_MISALIGN_CHECK_EN
        issue(MEMOP_LW, 5'd8, 1'b1, 32'h301, 32'd0);
        check("mis_exc", {exc_valid, exc_cause, dbus_req, exc_addr}, {1'b1, 2'd1, 1'b0, 32'h301});
        tick();
        check("mis_idle", {dbus_req, mem_wreg}, 37'd0);
`else
        do_load(MEMOP_LW, 5'd8, 32'h301, 0, 32'h1234_5678, 32'h1234_5678);
        check("mis_no_exc", 37'(exc_valid), 37'd0);
`endif
        tick();

        issue(MEMOP_LW, 5'd15, 1'b1, 32'h800, 32'd0);
        tick();
        check("rst_mid_req", 37'(dbus_req), 37'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_drop", {dbus_req, ex_ready, load_pending}, {1'b0, 1'b1, 1'b0});
        tick();
        rst = 1'b0;
        tick();
        sb.push_back({5'd10, 32'hCAFE});
        issue(MEMOP_NONE, 5'd10, 1'b1, 32'hCAFE, 32'd0);
        check("post_rst_mem", {mem_wreg, mem_wd, mem_wdata}, {1'b1, 5'd10, 32'hCAFE});
        tick(); tick();

        check("sb_empty", 37'(sb.size()), 37'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
